// File: rtl/fifo_acc_pkg.sv
// Shared types and sizing helpers for the multichannel FIFO accumulator and its reader.
package fifo_acc_pkg;

    localparam int DEF_CHANNEL_WIDTH = 32;

    typedef logic [DEF_CHANNEL_WIDTH-1:0] ch_word_t;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        READ         = 2'd1,
        DRAIN        = 2'd2,
        WAIT_RELEASE = 2'd3
    } rd_state_t;

    function automatic int ch_id_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    // One extra bit so the counter can represent CHANNEL_DEPTH itself.
    function automatic int wc_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_acc_reader_if.sv
// Accumulator read port plus the serialized output stream of the reader.
interface fifo_acc_reader_if #(
    parameter int CHANNELS_CNT  = 5,
    parameter int CHANNEL_WIDTH = 32
);
    localparam int CH_ID_W = fifo_acc_pkg::ch_id_w(CHANNELS_CNT);

    logic [CHANNELS_CNT-1:0]                    i_empty_channels;
    logic [CHANNELS_CNT-1:0]                    i_empty_next_channels;
    logic [CHANNELS_CNT-1:0][CHANNEL_WIDTH-1:0] i_rd_data_channels;
    logic [CHANNELS_CNT-1:0]                    o_rd_en_channels;
    logic [CHANNEL_WIDTH-1:0]                   o_tdata;
    logic [CH_ID_W-1:0]                         o_tuser;
    logic                                       o_tlast;
    logic                                       o_tvalid;
    logic                                       i_tready;

    modport master (
        input  i_empty_channels, i_empty_next_channels, i_rd_data_channels, i_tready,
        output o_rd_en_channels, o_tdata, o_tuser, o_tlast, o_tvalid
    );

    modport slave (
        output i_empty_channels, i_empty_next_channels, i_rd_data_channels, i_tready,
        input  o_rd_en_channels, o_tdata, o_tuser, o_tlast, o_tvalid
    );

endinterface

// File: rtl/fifo_acc_reader_stream_out_reg.sv
// Single-entry valid/ready output stage; load->tvalid in 1 cycle.
// Holds data/user/last while tvalid && !tready; o_free says a load may be accepted this cycle.
module stream_out_reg #(
    parameter int DATA_W = 32,
    parameter int USER_W = 1
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic [USER_W-1:0] i_user,
    input  logic              i_last,
    input  logic              i_tready,
    output logic              o_free,
    output logic [DATA_W-1:0] o_tdata,
    output logic [USER_W-1:0] o_tuser,
    output logic              o_tlast,
    output logic              o_tvalid
);

    logic [DATA_W-1:0] tdata_q, tdata_d;
    logic [USER_W-1:0] tuser_q, tuser_d;
    logic              tlast_q, tlast_d;
    logic              tvalid_q, tvalid_d;

    always_comb begin
        tdata_d  = tdata_q;
        tuser_d  = tuser_q;
        tlast_d  = tlast_q;
        tvalid_d = tvalid_q;
        if (i_load) begin
            tdata_d  = i_data;
            tuser_d  = i_user;
            tlast_d  = i_last;
            tvalid_d = 1'b1;
        end else if (i_tready) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            tdata_q  <= '0;
            tuser_q  <= '0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
        end else begin
            tdata_q  <= tdata_d;
            tuser_q  <= tuser_d;
            tlast_q  <= tlast_d;
            tvalid_q <= tvalid_d;
        end
    end

    assign o_free   = !tvalid_q || i_tready;
    assign o_tdata  = tdata_q;
    assign o_tuser  = tuser_q;
    assign o_tlast  = tlast_q;
    assign o_tvalid = tvalid_q;

endmodule

// File: rtl/fifo_acc_reader.sv
// Drains accumulator channels 0..N-1 in order onto one tagged stream; pop->tvalid in 1 cycle.
// Pops only when the output stage is free, so i_tready low stalls the FIFOs with no word lost.
module fifo_acc_reader
    import fifo_acc_pkg::*;
#(
    parameter int CHANNEL_WIDTH   = 32,
    parameter int CHANNEL_DEPTH   = 1024,
    parameter int CHANNELS_CNT    = 5,
    parameter int FRAME_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       i_rst,
    input  logic                       i_acc_valid,
    fifo_acc_reader_if.master          bus,
    output logic                       o_busy,
    output logic                       o_frame_done,
    output logic [FRAME_CNT_WIDTH-1:0] o_frame_cnt,
    output logic                       o_short_err
);

    localparam int CH_ID_W = ch_id_w(CHANNELS_CNT);
    localparam int WC_W    = wc_w(CHANNEL_DEPTH);
    localparam logic [WC_W-1:0]    WC_LAST = WC_W'(CHANNEL_DEPTH - 1);
    localparam logic [WC_W-1:0]    WC_FULL = WC_W'(CHANNEL_DEPTH);
    localparam logic [CH_ID_W-1:0] K_LAST  = CH_ID_W'(CHANNELS_CNT - 1);

    rd_state_t                state_q, state_d;
    logic [CH_ID_W-1:0]       k_q, k_d;
    logic [WC_W-1:0]          wc_q, wc_d, wc_inc;
    logic                     short_err_q, short_err_d;
    logic                     frame_done_q, frame_done_d;
    logic [FRAME_CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic [CHANNELS_CNT-1:0]  rd_en;
    logic                     free, pop, head_last, chan_end;

    always_ff @(posedge clk) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:         if (i_acc_valid) state_d = READ;
            READ:         if (chan_end && (k_q == K_LAST)) state_d = DRAIN;
            DRAIN:        if (free) state_d = WAIT_RELEASE;
            WAIT_RELEASE: if (!i_acc_valid) state_d = IDLE;
            default:      state_d = IDLE;
        endcase
    end

    // Pop is gated by reset so a mid-frame reset never steals a word from the FIFO.
    always_comb begin
        pop       = (state_q == READ) && free && !bus.i_empty_channels[k_q] && !i_rst;
        head_last = (wc_q == WC_LAST) || bus.i_empty_next_channels[k_q];
        chan_end  = (state_q == READ) && (pop ? head_last : bus.i_empty_channels[k_q]);
        wc_inc    = wc_q + WC_W'(pop);
        rd_en        = '0;
        rd_en[k_q]   = pop;

        k_d          = k_q;
        wc_d         = wc_q;
        short_err_d  = short_err_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (i_acc_valid) begin
                    k_d         = '0;
                    wc_d        = '0;
                    short_err_d = 1'b0;
                end
            end
            READ: begin
                wc_d = wc_inc;
                if (chan_end) begin
                    if (wc_inc < WC_FULL) short_err_d = 1'b1;
                    wc_d = '0;
                    if (k_q != K_LAST) k_d = k_q + CH_ID_W'(1);
                end
            end
            DRAIN: begin
                if (free) begin
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + FRAME_CNT_WIDTH'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            k_q          <= '0;
            wc_q         <= '0;
            short_err_q  <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            k_q          <= k_d;
            wc_q         <= wc_d;
            short_err_q  <= short_err_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    stream_out_reg #(
        .DATA_W (CHANNEL_WIDTH),
        .USER_W (CH_ID_W)
    ) u_out (
        .clk      (clk),
        .i_rst    (i_rst),
        .i_load   (pop),
        .i_data   (bus.i_rd_data_channels[k_q]),
        .i_user   (k_q),
        .i_last   (head_last),
        .i_tready (bus.i_tready),
        .o_free   (free),
        .o_tdata  (bus.o_tdata),
        .o_tuser  (bus.o_tuser),
        .o_tlast  (bus.o_tlast),
        .o_tvalid (bus.o_tvalid)
    );

    assign bus.o_rd_en_channels = rd_en;
    assign o_busy       = (state_q != IDLE);
    assign o_frame_done = frame_done_q;
    assign o_frame_cnt  = frame_cnt_q;
    assign o_short_err  = short_err_q;

endmodule

// File: tb/tb_fifo_acc_reader.sv
// Bench for fifo_acc_reader: 2 channels of depth 4 backed by queue FIFOs, scoreboard of expected beats.
module tb_fifo_acc_reader;

    localparam int CW    = 32;
    localparam int DEPTH = 4;
    localparam int NCH   = 2;
    localparam int FCW   = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           i_rst, i_acc_valid, o_busy, o_frame_done, o_short_err;
    logic [FCW-1:0] o_frame_cnt;

    fifo_acc_reader_if #(.CHANNELS_CNT(NCH), .CHANNEL_WIDTH(CW)) bus ();

    fifo_acc_reader #(
        .CHANNEL_WIDTH   (CW),
        .CHANNEL_DEPTH   (DEPTH),
        .CHANNELS_CNT    (NCH),
        .FRAME_CNT_WIDTH (FCW)
    ) dut (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_acc_valid  (i_acc_valid),
        .bus          (bus),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done),
        .o_frame_cnt  (o_frame_cnt),
        .o_short_err  (o_short_err)
    );

    typedef struct packed {
        logic [CW-1:0] d;
        logic          u;
        logic          l;
    } beat_t;

    typedef struct {
        int len0; int len1; int base0; int base1; int mode;
        int exp_beats; int exp_short; int exp_done_cyc;
    } vec_t;

    logic [CW-1:0] fq0[$];
    logic [CW-1:0] fq1[$];
    beat_t         expq[$];
    logic [NCH-1:0] pend;
    int n_chk = 0, n_fail = 0, frames_model = 0, under_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic refresh();
        bus.i_empty_channels      = {fq1.size() == 0, fq0.size() == 0};
        bus.i_empty_next_channels = {fq1.size() == 1, fq0.size() == 1};
        bus.i_rd_data_channels[0] = (fq0.size() > 0) ? fq0[0] : '0;
        bus.i_rd_data_channels[1] = (fq1.size() > 0) ? fq1[0] : '0;
    endtask

    // Apply pops granted last cycle, drive inputs after the edge, sample at the falling edge.
    task automatic next_cycle(input logic rdy, input logic av, input logic rst);
        logic [CW-1:0] tmp;
        @(posedge clk);
        #1;
        if (pend[0]) begin
            if (fq0.size() == 0) under_err++;
            else tmp = fq0.pop_front();
        end
        if (pend[1]) begin
            if (fq1.size() == 0) under_err++;
            else tmp = fq1.pop_front();
        end
        pend = '0;
        refresh();
        bus.i_tready = rdy;
        i_acc_valid  = av;
        i_rst        = rst;
        @(negedge clk);
        pend = bus.o_rd_en_channels;
    endtask

    task automatic load(input int len0, input int len1, input int base0, input int base1);
        fq0.delete();
        fq1.delete();
        for (int i = 0; i < len0; i++) fq0.push_back(CW'(base0 + i));
        for (int i = 0; i < len1; i++) fq1.push_back(CW'(base1 + i));
    endtask

    task automatic run_frame(input int len0, input int len1, input int base0, input int base1,
                             input int mode, input int exp_beats, input int exp_short,
                             input int exp_done_cyc, input bit drop_early);
        int n0, n1, cyc, acc, pops, last_acc, done_cyc, stab_err, bal_err, hold_err;
        bit done, prev_stall, rdy;
        logic [CW-1:0] pd;
        logic pu, pl;
        beat_t b;
        load(len0, len1, base0, base1);
        // Reference: each channel yields min(len, DEPTH) words, last flag on the final one.
        n0 = (len0 < DEPTH) ? len0 : DEPTH;
        n1 = (len1 < DEPTH) ? len1 : DEPTH;
        expq.delete();
        for (int i = 0; i < n0; i++) expq.push_back('{d: CW'(base0 + i), u: 1'b0, l: (i == n0 - 1)});
        for (int i = 0; i < n1; i++) expq.push_back('{d: CW'(base1 + i), u: 1'b1, l: (i == n1 - 1)});
        under_err = 0;
        cyc = 0; acc = 0; pops = 0; last_acc = 0; done_cyc = 0;
        stab_err = 0; bal_err = 0; done = 0; prev_stall = 0;
        pd = '0; pu = 1'b0; pl = 1'b0;
        while (!done && cyc < 300) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            next_cycle(rdy, !(drop_early && cyc >= 3), 1'b0);
            cyc++;
            if ($countones(bus.o_rd_en_channels) > 1) bal_err++;
            if (bus.o_rd_en_channels != 0) pops++;
            if (prev_stall && !(bus.o_tvalid && bus.o_tdata == pd && bus.o_tuser == pu && bus.o_tlast == pl))
                stab_err++;
            prev_stall = bus.o_tvalid && !bus.i_tready;
            pd = bus.o_tdata; pu = bus.o_tuser; pl = bus.o_tlast;
            if (bus.o_tvalid && bus.i_tready) begin
                acc++;
                last_acc = cyc;
                if (expq.size() > 0) begin
                    b = expq.pop_front();
                    chk("beat", 64'({bus.o_tdata, bus.o_tuser, bus.o_tlast}), 64'(b));
                end
            end
            if (pops - acc < 0 || pops - acc > 1) bal_err++;
            if (o_frame_done) begin
                done = 1;
                done_cyc = cyc;
            end
        end
        chk("frame_done_seen", 64'(done), 64'(1));
        if (done) begin
            frames_model++;
            chk("beat_count", 64'(acc), 64'(exp_beats));
            chk("short_err", 64'(o_short_err), 64'(exp_short));
            chk("frame_cnt", 64'(o_frame_cnt), 64'(frames_model % (1 << FCW)));
            chk("hold_stable", 64'(stab_err), 64'(0));
            chk("pop_balance", 64'(bal_err), 64'(0));
            chk("pop_underflow", 64'(under_err), 64'(0));
            chk("residual_ch0", 64'(fq0.size()), 64'(len0 - n0));
            chk("residual_ch1", 64'(fq1.size()), 64'(len1 - n1));
            if (exp_done_cyc != 0) chk("done_cycle", 64'(done_cyc), 64'(exp_done_cyc));
            if (len1 > 0 && acc > 0) chk("done_gap", 64'(done_cyc - last_acc), 64'(1));
            if (!drop_early) begin
                hold_err = 0;
                repeat (5) begin
                    next_cycle(1'b1, 1'b1, 1'b0);
                    if (o_frame_done || bus.o_rd_en_channels != 0 || !o_busy || bus.o_tvalid) hold_err++;
                end
                chk("no_retrigger", 64'(hold_err), 64'(0));
            end
        end
        next_cycle(1'b1, 1'b0, 1'b0);
        next_cycle(1'b1, 1'b0, 1'b0);
        chk("release_idle", 64'(o_busy), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 50000 cycles");
        $fatal(1);
    end

    initial begin
        vec_t tbl[6];
        int acc, guard, l0, l1, eb, es;
        pend = '0;
        i_rst = 1'b1;
        i_acc_valid = 1'b0;
        bus.i_tready = 1'b0;
        bus.i_rd_data_channels = '0;
        refresh();
        repeat (3) next_cycle(1'b0, 1'b0, 1'b1);
        next_cycle(1'b0, 1'b0, 1'b0);
        chk("rst_tvalid",     64'(bus.o_tvalid), 64'(0));
        chk("rst_rd_en",      64'(bus.o_rd_en_channels), 64'(0));
        chk("rst_busy",       64'(o_busy), 64'(0));
        chk("rst_frame_done", 64'(o_frame_done), 64'(0));
        chk("rst_frame_cnt",  64'(o_frame_cnt), 64'(0));
        chk("rst_short_err",  64'(o_short_err), 64'(0));

        //           len0 len1 base0 base1 mode beats short done_cyc
        tbl[0] = '{4, 4, 1, 5, 0, 8, 0, 11};
        tbl[1] = '{4, 4, 1, 5, 1, 8, 0, 0};
        tbl[2] = '{4, 2, 1, 9, 0, 6, 1, 9};
        tbl[3] = '{0, 0, 1, 5, 0, 0, 1, 5};
        tbl[4] = '{6, 4, 1, 5, 0, 8, 0, 11};
        tbl[5] = '{1, 5, 20, 40, 2, 5, 1, 0};
        for (int t = 0; t < 6; t++)
            run_frame(tbl[t].len0, tbl[t].len1, tbl[t].base0, tbl[t].base1, tbl[t].mode,
                      tbl[t].exp_beats, tbl[t].exp_short, tbl[t].exp_done_cyc, 1'b0);

        // Reset one cycle after three accepted beats, then a clean restart from channel 0.
        load(4, 4, 1, 5);
        acc = 0;
        guard = 0;
        while (acc < 3 && guard < 40) begin
            next_cycle(1'b1, 1'b1, 1'b0);
            guard++;
            if (bus.o_tvalid && bus.i_tready) acc++;
        end
        chk("rst_seq_beats", 64'(acc), 64'(3));
        next_cycle(1'b1, 1'b0, 1'b1);
        chk("rst_cycle_no_pop", 64'(bus.o_rd_en_channels), 64'(0));
        next_cycle(1'b1, 1'b0, 1'b0);
        chk("midrst_tvalid",    64'(bus.o_tvalid), 64'(0));
        chk("midrst_rd_en",     64'(bus.o_rd_en_channels), 64'(0));
        chk("midrst_busy",      64'(o_busy), 64'(0));
        chk("midrst_frame_cnt", 64'(o_frame_cnt), 64'(0));
        chk("midrst_done",      64'(o_frame_done), 64'(0));
        frames_model = 0;
        run_frame(4, 4, 1, 5, 0, 8, 0, 11, 1'b0);

        for (int r = 0; r < 8; r++) begin
            l0 = $urandom_range(0, 6);
            l1 = $urandom_range(0, 6);
            eb = ((l0 < DEPTH) ? l0 : DEPTH) + ((l1 < DEPTH) ? l1 : DEPTH);
            es = (l0 < DEPTH || l1 < DEPTH) ? 1 : 0;
            run_frame(l0, l1, $urandom_range(0, 65535), $urandom_range(0, 65535), 2,
                      eb, es, 0, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_acc_reader.md
Name: fifo_acc_reader

Overview:
- Drain-side counterpart of the multichannel FIFO accumulator.
- Once the accumulator flags a finished accumulation (level `i_acc_valid`), this block reads channels 0..CHANNELS_CNT-1 in order. It pops each channel until it is empty or CHANNEL_DEPTH words have been read.
- Words are serialized onto a single valid/ready stream, tagged with the channel ID, with a per-channel last flag.
- It sits between the accumulator's read port and the readout/DMA path.

Parameters:
CHANNEL_WIDTH, 32, data word width
CHANNEL_DEPTH, 1024, maximum words per channel per frame
CHANNELS_CNT, 5, number of channels (>=1)
FRAME_CNT_WIDTH, 16, width of completed-frame counter

Ports:
clk  in  1  clock
i_rst  in  1  reset
i_acc_valid  in  1  accumulation done, level; held by accumulator until all channels empty
i_empty_channels  in  CHANNELS_CNT  per-channel FIFO empty (FWFT)
i_empty_next_channels  in  CHANNELS_CNT  per-channel: exactly one word left
i_rd_data_channels  in  CHANNELS_CNT x CHANNEL_WIDTH  FWFT head word, valid when not empty
o_rd_en_channels  out  CHANNELS_CNT  pop strobe, at most one bit set
o_tdata  out  CHANNEL_WIDTH  output word
o_tuser  out  CH_ID_W = max(1,$clog2(CHANNELS_CNT))  channel ID of o_tdata
o_tlast  out  1  last word of current channel
o_tvalid  out  1  output valid
i_tready  in  1  downstream ready
o_busy  out  1  state != IDLE
o_frame_done  out  1  one-cycle pulse, frame fully transferred
o_frame_cnt  out  FRAME_CNT_WIDTH  completed frames, wraps
o_short_err  out  1  sticky: some channel ended with < CHANNEL_DEPTH words; cleared by reset or next frame start

Behaviour:
- Reset: synchronous, active-high `i_rst` on rising edge of `clk`.
  - Values: state=IDLE; channel index k=0; word count wc=0; all outputs 0; o_frame_cnt=0.
  - Reset mid-frame: any pending output word is discarded, no pop occurs in the reset cycle, and there is no partial frame_done.
- Output register: a single output stage with `free = !o_tvalid || i_tready`.
- Pop condition: `pop = (state==READ) && free && !i_empty_channels[k]`.
  - `o_rd_en_channels` is combinational one-hot, bit k = pop.
  - On pop, the register loads tdata=i_rd_data_channels[k], tuser=k, tvalid=1.
  - Latency is one cycle from pop to o_tvalid.
  - If `i_tready && !pop`, then tvalid<=0.
  - While `o_tvalid && !i_tready`, tdata, tuser and tlast hold.
- tlast is loaded with `(wc==CHANNEL_DEPTH-1) || i_empty_next_channels[k]`.
- FSM states: IDLE, READ, DRAIN, WAIT_RELEASE.
  - IDLE: when i_acc_valid=1 -> READ; k<=0, wc<=0, short_err<=0.
  - READ, on pop: wc<=wc+1.
  - READ, channel end: when a pop carries tlast, or when i_empty_channels[k]=1 with no pop this cycle.
    - If wc+pop < CHANNEL_DEPTH, set short_err.
    - wc<=0.
    - If k==CHANNELS_CNT-1 -> DRAIN, else k<=k+1.
  - Empty channel (wc=0, empty): contributes no beats, sets short_err, and advances in 1 cycle.
  - DRAIN: wait until `!o_tvalid || i_tready` (the final word is accepted), then:
    - pulse o_frame_done;
    - o_frame_cnt<=o_frame_cnt+1, wrapping at 2^FRAME_CNT_WIDTH;
    - go to WAIT_RELEASE.
  - WAIT_RELEASE: when i_acc_valid=0 -> IDLE. No pops in this state. This prevents re-triggering on the same level.
- wc width is $clog2(CHANNEL_DEPTH)+1. No pops beyond CHANNEL_DEPTH even if the FIFO is not empty; excess words remain for the accumulator's reset.
- i_acc_valid dropping during READ/DRAIN is ignored; the frame completes on FIFO contents.
- Throughput: 1 word/cycle with i_tready=1; there is no bubble between channels except for empty channels.

Decomposition:
- Package fifo_acc_pkg holds:
  - the state enum (`rd_state_t`);
  - CH_ID_W and the wc width helper functions;
  - the shared channel-width typedef, shared with the accumulator.
- Sub-module `stream_out_reg` is the output register/hold stage: load, tvalid, tready, tdata, tuser, tlast.
- The FSM and counters remain top-level.

Test Plan:
- CH=2, DEPTH=4, ch0={1,2,3,4}, ch1={5,6,7,8}, tready=1, raise acc_valid:
  - 8 consecutive beats with tuser 0,0,0,0,1,1,1,1 and tlast on beats 4 and 8;
  - frame_done 1 cycle after beat 8; frame_cnt=1; short_err=0.
- Same data with tready pattern 1,0,1,0…:
  - exactly 8 beats in order, no duplicates;
  - tdata/tuser/tlast stable while valid&&!ready;
  - never more than one pop per accepted beat.
- ch1 holds only {9,10}:
  - ch1 beats = 9,10 with tlast on 10;
  - short_err=1; frame_done still asserts.
- All channels empty at acc_valid rise:
  - zero beats; DRAIN reached after CHANNELS_CNT cycles;
  - frame_done pulse; short_err=1.
- i_rst for 1 cycle after 3 accepted beats:
  - next cycle tvalid=0, rd_en=0, busy=0, frame_cnt=0;
  - after the acc_valid re-rise, the frame restarts at ch0.
- Two frames, with acc_valid held 5 cycles past frame_done between them:
  - no re-trigger while held;
  - frame_cnt=2 after the second frame_done.
